// File: rtl/cluster_event_sink.sv
// Cluster-side reader of a Gray-pointer CDC event buffer written from the SoC domain.
// Events appear SYNC_STAGES+1 edges after a write pointer change; the output register reloads on accept with no bubble.
module cluster_event_sink #(
    parameter int DATA_WIDTH  = 8,
    parameter int LOG_DEPTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [LOG_DEPTH:0]                    wptr_gray_async_i,
    input  logic [(2**LOG_DEPTH)*DATA_WIDTH-1:0]  data_async_i,
    output logic [LOG_DEPTH:0]                    rptr_gray_o,
    output logic                                  evt_valid_o,
    input  logic                                  evt_ready_i,
    output logic [DATA_WIDTH-1:0]                 evt_data_o,
    output logic [LOG_DEPTH:0]                    level_o,
    output logic                                  overflow_o
);

    localparam int PW    = LOG_DEPTH + 1;
    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic [PW-1:0]         wptr_sync;
    logic [PW-1:0]         wptr_bin;
    logic [PW-1:0]         rptr_bin;
    logic [PW-1:0]         diff;
    logic [LOG_DEPTH-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] slot [DEPTH];
    logic                  empty;
    logic                  pop;

    // Only the Gray-coded pointer crosses domains through flops; the payload is
    // sampled directly because the source never rewrites a slot before our read
    // pointer has returned past it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr_gray_async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign slot[k] = data_async_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign wptr_sync = sync_q[SYNC_STAGES-1];
    assign wptr_bin  = gray2bin(wptr_sync);
    assign diff      = wptr_bin - rptr_bin;
    assign empty     = (wptr_bin == rptr_bin);
    assign pop       = !empty && (!evt_valid_o || evt_ready_i);
    assign rd_idx    = rptr_bin[LOG_DEPTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_bin    <= '0;
            rptr_gray_o <= '0;
            evt_valid_o <= 1'b0;
            evt_data_o  <= '0;
            level_o     <= '0;
            overflow_o  <= 1'b0;
        end else begin
            rptr_gray_o <= bin2gray(rptr_bin);
            level_o     <= diff;
            if (diff > DEPTH_LVL) begin
                overflow_o <= 1'b1;
            end
            if (pop) begin
                evt_data_o  <= slot[rd_idx];
                evt_valid_o <= 1'b1;
                rptr_bin    <= rptr_bin + 1'b1;
            end else if (evt_ready_i) begin
                evt_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cluster_event_sink.sv
// Directed bench for cluster_event_sink: TB source model plus an in-order scoreboard on the event port.
module tb_cluster_event_sink;

    localparam int DW    = 8;
    localparam int LD    = 3;
    localparam int SS    = 2;
    localparam int PW    = LD + 1;
    localparam int DEPTH = 2 ** LD;

    logic                  clk = 1'b0;
    logic                  src_clk = 1'b0;
    logic                  rst = 1'b1;
    logic [PW-1:0]         wptr_g = '0;
    logic [DEPTH*DW-1:0]   data_bus = '0;
    logic [PW-1:0]         rptr_g;
    logic                  evt_valid;
    logic                  evt_ready = 1'b0;
    logic [DW-1:0]         evt_data;
    logic [PW-1:0]         level;
    logic                  overflow;

    logic [PW-1:0]         src_w = '0;
    logic                  sb_en = 1'b1;
    logic                  src_done = 1'b0;
    int                    src_half = 18;
    int                    n_cmp = 0;
    int                    n_err = 0;
    logic [DW-1:0]         exp_q [$];

    cluster_event_sink #(.DATA_WIDTH(DW), .LOG_DEPTH(LD), .SYNC_STAGES(SS)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .wptr_gray_async_i (wptr_g),
        .data_async_i      (data_bus),
        .rptr_gray_o       (rptr_g),
        .evt_valid_o       (evt_valid),
        .evt_ready_i       (evt_ready),
        .evt_data_o        (evt_data),
        .level_o           (level),
        .overflow_o        (overflow)
    );

    always #6 clk = ~clk;
    initial begin
        #1;
        forever #(src_half) src_clk = ~src_clk;
    end

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic src_full();
        logic [PW-1:0] used;
        used = src_w - g2b(rptr_g);
        return used == PW'(DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic src_write(input logic [DW-1:0] d);
        data_bus[src_w[LD-1:0]*DW +: DW] = d;
        src_w  = src_w + 1'b1;
        wptr_g = b2g(src_w);
        exp_q.push_back(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!evt_valid && k < budget) begin
            step();
            k++;
        end
        check(tag, evt_valid, 1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        evt_ready = 1'b1;
        while ((exp_q.size() != 0 || evt_valid) && k < 400) begin
            step();
            k++;
        end
        repeat (3) step();
        check(tag, exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        src_w = '0;
        wptr_g = '0;
        exp_q.delete();
        evt_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, evt_valid, 0);
        check({tag, "_data"},  evt_data, 0);
        check({tag, "_rptr"},  rptr_g, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_ovf"},   overflow, 0);
    endtask

    // Handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && sb_en && evt_valid && evt_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0)
            else begin
                n_err++;
                $error("FAIL sb_extra: observed 0x%0h, expected no event", evt_data);
            end
            if (exp_q.size() != 0) check("sb_order", evt_data, exp_q.pop_front());
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #3;
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Single event latency, pointer return, level
        evt_ready = 1'b1;
        src_write(8'hA5);
        step(); check("t1_lat1", evt_valid, 0);
        step(); check("t1_lat2", evt_valid, 0);
        step();
        check("t1_valid", evt_valid, 1);
        check("t1_data", evt_data, 8'hA5);
        check("t1_rptr_pre", rptr_g, 0);
        check("t1_level1", level, 1);
        step();
        check("t1_valid_drop", evt_valid, 0);
        check("t1_rptr", rptr_g, 4'b0001);
        check("t1_level0", level, 0);

        // Backpressure
        evt_ready = 1'b0;
        src_write(8'h11); step();
        src_write(8'h22); step();
        src_write(8'h33);
        wait_valid("t2_first", 10);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_hold_valid", evt_valid, 1);
            check("t2_hold_data", evt_data, 8'h11);
        end
        check("t2_level", level, 2);
        evt_ready = 1'b1;
        step(); check("t2_b2b_v22", evt_valid, 1); check("t2_b2b_d22", evt_data, 8'h22);
        step(); check("t2_b2b_v33", evt_valid, 1); check("t2_b2b_d33", evt_data, 8'h33);
        step(); check("t2_empty", evt_valid, 0);

        // Wrap-around streaming with source respecting full
        for (int i = 0; i < 20; i++) begin
            int k = 0;
            while (src_full() && k < 200) begin
                step();
                k++;
            end
            src_write(8'h40 + 8'(i));
            step();
            check("t3_no_ovf", overflow, 0);
        end
        drain("t3_drain");
        check("t3_rptr", rptr_g, b2g(src_w));
        check("t3_level", level, 0);
        check("t3_ovf_end", overflow, 0);

        // Overflow: pointer jumps to 9 with read pointer at 0
        apply_reset();
        sb_en = 1'b0;
        wptr_g = b2g(4'd9);
        repeat (5) step();
        check("t4_ovf_set", overflow, 1);
        check("t4_level", level, 8);
        evt_ready = 1'b1;
        repeat (20) step();
        check("t4_ovf_sticky", overflow, 1);
        check("t4_pops_done", rptr_g, b2g(4'd9));
        check("t4_valid_idle", evt_valid, 0);
        apply_reset();
        check("t4_ovf_cleared", overflow, 0);
        sb_en = 1'b1;

        // Reset mid-stream drops in-flight events
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_write(8'hC0 + 8'(i));
            step();
        end
        begin
            int k = 0;
            while (level != 3 && k < 20) begin
                step();
                k++;
            end
        end
        check("t5_pre_valid", evt_valid, 1);
        check("t5_pre_level", level, 3);
        #3;
        rst = 1'b1;
        wptr_g = '0;
        src_w = '0;
        exp_q.delete();
        #1;
        check_all_zero("t5_async");
        step();
        rst = 1'b0;
        evt_ready = 1'b1;
        repeat (10) step();
        check("t5_no_event", evt_valid, 0);
        check("t5_level", level, 0);

        // Release with a pending write already on the pointer
        rst = 1'b1;
        evt_ready = 1'b1;
        src_write(8'h5C);
        step();
        rst = 1'b0;
        wait_valid("t6_pending", 10);
        check("t6_data", evt_data, 8'h5C);
        drain("t6_drain");

        // CDC ratios: slow source then fast source, random consumer
        for (int r = 0; r < 2; r++) begin
            apply_reset();
            src_half = (r == 0) ? 18 : 2;
            src_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 30; i++) begin
                        int k = 0;
                        @(posedge src_clk);
                        while (src_full() && k < 1000) begin
                            @(posedge src_clk);
                            k++;
                        end
                        src_write(8'($urandom));
                    end
                    src_done = 1'b1;
                end
                begin
                    while (!src_done) begin
                        step();
                        evt_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            drain("t7_drain");
            check("t7_rptr", rptr_g, b2g(src_w));
            check("t7_ovf", overflow, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cluster_event_sink.md
CLUSTER_EVENT_SINK -- requirements
Module: cluster_event_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: event word width, matching EVNT_WIDTH.
REQ-002 SHALL have parameter LOG_DEPTH, default 3: source buffer holds 2**LOG_DEPTH slots.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flop count of the pointer synchronizer, legal range 2..4.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk_i, input, 1 bit: sink-side clock (cluster clock).
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous reset, active-high.
REQ-007 SHALL have port wptr_gray_async_i, input, LOG_DEPTH+1 bits: Gray-coded write pointer from the SoC-domain source, asynchronous to clk_i.
REQ-008 SHALL have port data_async_i, input, (2**LOG_DEPTH)*DATA_WIDTH bits: flattened source buffer; slot k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port rptr_gray_o, output, LOG_DEPTH+1 bits: registered Gray-coded read pointer returned to the source.
REQ-010 SHALL have port evt_valid_o, output, 1 bit: evt_data_o holds an event.
REQ-011 SHALL have port evt_ready_i, input, 1 bit: the consumer accepts an event.
REQ-012 SHALL have port evt_data_o, output, DATA_WIDTH bits: event payload.
REQ-013 SHALL have port level_o, output, LOG_DEPTH+1 bits: entries pending in the source buffer, excluding the output register.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-015 SHALL pass wptr_gray_async_i through SYNC_STAGES flops to form wptr_sync, then convert wptr_sync from Gray to binary as wptr_bin.
REQ-016 SHALL keep rptr_bin, LOG_DEPTH+1 bits, which wraps modulo 2**(LOG_DEPTH+1).
REQ-017 SHALL compute empty = (wptr_bin == rptr_bin).
REQ-018 SHALL fire pop when !empty and (!evt_valid_o or evt_ready_i).
- On pop: evt_data_o <= slot[rptr_bin[LOG_DEPTH-1:0]], evt_valid_o <= 1, rptr_bin <= rptr_bin+1.
REQ-019 SHALL clear evt_valid_o on the next edge when evt_valid_o and evt_ready_i are both high and empty is high.
REQ-020 SHALL hold evt_valid_o and evt_data_o stable while evt_valid_o=1 and evt_ready_i=0.
REQ-021 SHALL, on a simultaneous accept and pop, reload the output register in the same cycle with no bubble, sustaining 1 event/cycle.
REQ-022 SHALL register rptr_gray_o = bin2gray(rptr_bin) one cycle after each rptr_bin update, so exactly one bit changes per increment.
REQ-023 SHALL present an event on evt_valid_o SYNC_STAGES+1 clk_i edges after a wptr_gray_async_i change, with the output register empty.
REQ-024 SHALL compute level_o = (wptr_bin - rptr_bin) modulo 2**(LOG_DEPTH+1), registered.
REQ-025 SHALL set overflow_o and hold it until reset when the computed difference exceeds 2**LOG_DEPTH.
- The pop logic SHALL keep operating after overflow_o is set.
REQ-026 SHALL handle wrap: rptr_bin 2**(LOG_DEPTH+1)-1 -> 0, and the slot index wraps 7 -> 0 at default parameters.
REQ-027 SHALL NOT read data_async_i except at the slot selected by rptr_bin on a pop.

Reset
REQ-028 SHALL, on rst_i high, asynchronously clear:
- all synchronizer flops, rptr_bin and rptr_gray_o to 0;
- evt_valid_o, evt_data_o, level_o and overflow_o to 0.
REQ-029 SHALL drop any in-flight event when rst_i asserts mid-operation, without presenting it after release.
- The source domain SHALL be reset concurrently.
REQ-030 SHALL treat a release with nonzero wptr_gray_async_i as pending writes, and pop them normally.

Verification
REQ-031 SHALL cover single event:
- Stimulus: slot0=0xA5, wptr 0->1 (gray 0001), evt_ready_i=1.
- Response: evt_valid_o high with 0xA5 on cycle SYNC_STAGES+1 for one cycle; rptr_gray_o=0001 one cycle later; level_o returns to 0.
REQ-032 SHALL cover backpressure:
- Stimulus: 3 events 0x11,0x22,0x33, evt_ready_i=0 for 10 cycles, then 1.
- Response: 0x11 is held stable; then 0x11,0x22,0x33 appear on consecutive cycles; level_o=2 while stalled.
REQ-033 SHALL cover wrap-around:
- Stimulus: 20 events streamed with the source respecting full.
- Response: payloads in order; rptr_bin wraps 15->0; overflow_o stays 0.
REQ-034 SHALL cover overflow:
- Stimulus: force wptr_gray to gray(9) with rptr=0 at LOG_DEPTH=3.
- Response: overflow_o=1 and sticky until rst_i.
REQ-035 SHALL cover reset mid-stream:
- Stimulus: assert rst_i with evt_valid_o=1 and level_o=3, wptr driven to 0.
- Response: all outputs 0 asynchronously; no event after release.
REQ-036 SHALL cover CDC jitter:
- Stimulus: clk_i/source clock ratios 1:3 and 3:1 with random evt_ready_i.
- Response: scoreboard shows no loss, duplication or reordering.
